// File: rtl/i2s_aud_rx_if.sv
// Output bundle of the I2S receiver: one left/right sample pair plus event strobes and debug taps.
// aud_vld is a one-cycle strobe with no ready: the consumer must take lft_aud/rht_aud on the pulse; both hold until the next pulse.
interface i2s_aud_rx_if;
    logic [15:0] lft_aud;
    logic [15:0] rht_aud;
    logic        aud_vld;
    logic        frm_err;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_pins;

    modport master (output lft_aud, rht_aud, aud_vld, frm_err, dbg_state, dbg_pins);
    modport slave  (input  lft_aud, rht_aud, aud_vld, frm_err, dbg_state, dbg_pins);
endinterface

// File: rtl/i2s_aud_rx.sv
// I2S receiver: synchronizes SCLK/LRCLK/SDATA into clk and deserializes
// 16-bit MSB-first left/right words into a paired output with a valid strobe.
module i2s_aud_rx (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          lrclk,
    input  logic          sdata,
    i2s_aud_rx_if.master  aud
);

    typedef enum logic [1:0] {SYNC = 2'd0, LFT = 2'd1, RHT = 2'd2} state_t;

    // Index 0 = s1, 1 = s2, 2 = s3
    logic [2:0]  sclk_sync, lrclk_sync, sdata_sync;
    state_t      state, state_nxt;
    logic [4:0]  bit_cnt, cnt_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic [15:0] lft_hold, hold_nxt;
    logic [15:0] lft_q, lft_nxt;
    logic [15:0] rht_q, rht_nxt;
    logic        vld_q, vld_nxt;
    logic        err_q, err_nxt;
    logic        ws_prev;

    logic        rise, ws, bit_in, can_shift, trans;
    logic [4:0]  post_cnt;
    logic [15:0] post_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= 3'b000;
            lrclk_sync <= 3'b000;
            sdata_sync <= 3'b000;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], sclk};
            lrclk_sync <= {lrclk_sync[1:0], lrclk};
            sdata_sync <= {sdata_sync[1:0], sdata};
        end
    end

    assign rise   = sclk_sync[1] & ~sclk_sync[2];
    assign ws     = lrclk_sync[1];
    assign bit_in = sdata_sync[1];
    assign trans  = (ws != ws_prev);

    // The LSB of a word arrives on the first rise of the next slot, so the
    // shift is applied before the end-of-slot count check.
    assign can_shift = (bit_cnt < 5'd16);
    assign post_cnt  = can_shift ? (bit_cnt + 5'd1) : bit_cnt;
    assign post_sh   = can_shift ? {shreg[14:0], bit_in} : shreg;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shreg_nxt = shreg;
        hold_nxt  = lft_hold;
        lft_nxt   = lft_q;
        rht_nxt   = rht_q;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (rise) begin
            case (state)
                SYNC: begin
                    if (ws_prev && !ws) begin
                        cnt_nxt   = 5'd0;
                        state_nxt = LFT;
                    end
                end
                LFT: begin
                    shreg_nxt = post_sh;
                    cnt_nxt   = post_cnt;
                    if (trans) begin
                        if (post_cnt == 5'd16) begin
                            hold_nxt  = post_sh;
                            cnt_nxt   = 5'd0;
                            state_nxt = RHT;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = SYNC;
                        end
                    end
                end
                RHT: begin
                    shreg_nxt = post_sh;
                    cnt_nxt   = post_cnt;
                    if (trans) begin
                        // A short right slot still ends on a valid left start.
                        if (post_cnt == 5'd16) begin
                            lft_nxt = lft_hold;
                            rht_nxt = post_sh;
                            vld_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        cnt_nxt   = 5'd0;
                        state_nxt = LFT;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            bit_cnt  <= 5'd0;
            shreg    <= 16'd0;
            lft_hold <= 16'd0;
            lft_q    <= 16'd0;
            rht_q    <= 16'd0;
            ws_prev  <= 1'b1;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= cnt_nxt;
            shreg    <= shreg_nxt;
            lft_hold <= hold_nxt;
            lft_q    <= lft_nxt;
            rht_q    <= rht_nxt;
            vld_q    <= vld_nxt;
            err_q    <= err_nxt;
            if (rise) ws_prev <= ws;
        end
    end

    assign aud.lft_aud   = lft_q;
    assign aud.rht_aud   = rht_q;
    assign aud.aud_vld   = vld_q;
    assign aud.frm_err   = err_q;
    assign aud.dbg_state = state;
    assign aud.dbg_pins  = {sclk_sync[2], lrclk_sync[2], sdata_sync[2]};

endmodule

// File: tb/tb_i2s_aud_rx.sv
// Directed bench for i2s_aud_rx: table of frames with hand-computed results,
// plus hand-written reset, latency and back-to-back sequences.
module tb_i2s_aud_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic lrclk = 1'b1;
  logic sdata = 1'b0;

  i2s_aud_rx_if aud ();

  i2s_aud_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .lrclk (lrclk),
    .sdata (sdata),
    .aud   (aud.master)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          nl;
    int          nr;
    int          half;
    int          exp_vld;
    int          exp_err;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[7];

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  logic vld_prev = 1'b0;
  logic pending = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every aud_vld must be one cycle wide and match the queued pair.
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (aud.aud_vld) begin
        logic [31:0] e;
        vld_cnt++;
        chk("vld_width", {31'd0, vld_prev}, 32'd0);
        chk("vld_err_overlap", {31'd0, aud.frm_err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pair", {aud.lft_aud, aud.rht_aud}, e);
        end
      end
      if (aud.frm_err) err_cnt++;
      vld_prev = aud.aud_vld;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // One SCLK period; data and word select change at the falling edge.
  task automatic rise(input logic w, input logic b, input int half);
    sclk = 1'b0;
    lrclk = w;
    sdata = b;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Slot position 0 carries the previous word's LSB; MSB at position 1.
  task automatic send_slot(input logic w, input logic [15:0] word, input int n,
                           input int half, input bit first);
    for (int i = (first ? 0 : 1); i < n; i++) begin
      logic b;
      int k;
      k = 16 - i;
      if (i == 0) b = pending;
      else if (i <= 16) b = word[k];
      else b = 1'($urandom_range(0, 1));
      rise(w, b, half);
    end
    if (n == 16) pending = word[0];
    else pending = 1'($urandom_range(0, 1));
  endtask

  // Left slot start rise is assumed already sent; optionally sends the closing left-start rise.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                            input int nr, input int half, input bit close);
    send_slot(1'b0, l, nl, half, 1'b0);
    send_slot(1'b1, r, nr, half, 1'b1);
    if (close) rise(1'b0, pending, half);
  endtask

  initial begin
    int v0, e0;
    logic [15:0] rl, rr;

    vecs[0] = '{16'h7FFF, 16'h8001, 32, 32, 8, 1, 0, 16'h7FFF, 16'h8001};
    vecs[1] = '{16'h1234, 16'hABCD, 16, 16, 4, 1, 0, 16'h1234, 16'hABCD};
    vecs[2] = '{16'h5555, 16'h6666, 10, 16, 4, 0, 1, 16'h1234, 16'hABCD};
    vecs[3] = '{16'h0F0F, 16'hF0F0, 24, 24, 4, 1, 0, 16'h0F0F, 16'hF0F0};
    vecs[4] = '{16'h1111, 16'h2222, 16, 12, 4, 0, 1, 16'h0F0F, 16'hF0F0};
    vecs[5] = '{16'hFFFF, 16'h0000, 16, 16, 4, 1, 0, 16'hFFFF, 16'h0000};
    vecs[6] = '{16'h8000, 16'h0001, 20, 17, 4, 1, 0, 16'h8000, 16'h0001};

    // Clock/reset
    repeat (3) @(negedge clk);
    chk("rst_lft", {16'd0, aud.lft_aud}, 32'd0);
    chk("rst_rht", {16'd0, aud.rht_aud}, 32'd0);
    chk("rst_vld", {31'd0, aud.aud_vld}, 32'd0);
    chk("rst_err", {31'd0, aud.frm_err}, 32'd0);
    chk("rst_state", {30'd0, aud.dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Preamble: right-slot rises, then the first left start
    rise(1'b1, 1'b0, 4);
    rise(1'b1, 1'b0, 4);
    rise(1'b0, 1'b0, 4);
    chk("pre_state_lft", {30'd0, aud.dbg_state}, 32'd1);
    chk("pre_no_vld", vld_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      if (vecs[i].exp_vld == 1) exp_q.push_back({vecs[i].exp_l, vecs[i].exp_r});
      send_frame(vecs[i].l, vecs[i].r, vecs[i].nl, vecs[i].nr, vecs[i].half, 1'b1);
      chk($sformatf("vec%0d_vld_cnt", i), vld_cnt - v0, vecs[i].exp_vld);
      chk($sformatf("vec%0d_err_cnt", i), err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_lft", i), {16'd0, aud.lft_aud}, {16'd0, vecs[i].exp_l});
      chk($sformatf("vec%0d_rht", i), {16'd0, aud.rht_aud}, {16'd0, vecs[i].exp_r});
    end

    // Latency: raw SCLK rise -> aud_vld high after the third clk edge, low after the fourth
    exp_q.push_back({16'h0F00, 16'h00F0});
    send_frame(16'h0F00, 16'h00F0, 16, 16, 4, 1'b0);
    sclk = 1'b0;
    lrclk = 1'b0;
    sdata = pending;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_edge2", {31'd0, aud.aud_vld}, 32'd0);
    @(negedge clk);
    chk("lat_edge3", {31'd0, aud.aud_vld}, 32'd1);
    @(negedge clk);
    chk("lat_edge4", {31'd0, aud.aud_vld}, 32'd0);
    chk("lat_lft", {16'd0, aud.lft_aud}, 32'h0F00);
    repeat (2) @(negedge clk);

    // Back-to-back random frames
    v0 = vld_cnt;
    e0 = err_cnt;
    for (int f = 0; f < 100; f++) begin
      int nl, nr;
      rl = 16'($urandom);
      rr = 16'($urandom);
      nl = ($urandom_range(0, 1) == 1) ? 16 : 24;
      nr = ($urandom_range(0, 1) == 1) ? 16 : 24;
      exp_q.push_back({rl, rr});
      send_frame(rl, rr, nl, nr, 4, 1'b1);
    end
    chk("b2b_vld_cnt", vld_cnt - v0, 100);
    chk("b2b_err_cnt", err_cnt - e0, 0);
    chk("b2b_q_empty", exp_q.size(), 0);

    // Reset mid left slot: outputs clear without waiting for a clock edge
    send_slot(1'b0, 16'h3C3C, 8, 4, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lft", {16'd0, aud.lft_aud}, 32'd0);
    chk("mid_rst_rht", {16'd0, aud.rht_aud}, 32'd0);
    chk("mid_rst_vld", {31'd0, aud.aud_vld}, 32'd0);
    chk("mid_rst_err", {31'd0, aud.frm_err}, 32'd0);
    chk("mid_rst_state", {30'd0, aud.dbg_state}, 32'd0);
    chk("mid_rst_pins", {29'd0, aud.dbg_pins}, 32'd0);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Remainder of the interrupted left slot is too short: one frm_err, no aud_vld
    v0 = vld_cnt;
    e0 = err_cnt;
    send_slot(1'b0, 16'h3C3C, 7, 4, 1'b1);
    send_slot(1'b1, 16'h9999, 16, 4, 1'b1);
    rise(1'b0, pending, 4);
    chk("post_rst_no_vld", vld_cnt - v0, 0);
    chk("post_rst_err", err_cnt - e0, 1);
    chk("post_rst_lft_held", {16'd0, aud.lft_aud}, 32'd0);

    exp_q.push_back({16'h2468, 16'h1357});
    send_frame(16'h2468, 16'h1357, 16, 16, 4, 1'b1);
    chk("post_rst_vld", vld_cnt - v0, 1);
    chk("post_rst_lft", {16'd0, aud.lft_aud}, 32'h2468);
    chk("post_rst_rht", {16'd0, aud.rht_aud}, 32'h1357);
    chk("final_q_empty", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_aud_rx.md
# i2s_aud_rx

Serial audio receiver that deserializes the codec's I2S stream (SCLK, LRCLK, SDATA) into paired signed 16-bit left and right samples. It sits directly upstream of the amplitude averaging stage and drives its `lft_aud`, `rht_aud` and `aud_vld` inputs. All codec pins are asynchronous to the system clock and are synchronized inside this block.

## Interface
- Parameters: none. Sample width is fixed at 16 bits. Codec slot width is 16 or more SCLKs per channel.
- `clk` in 1: 50MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sclk` in 1: codec bit clock, asynchronous to `clk`.
- `lrclk` in 1: codec word select, asynchronous. 0 = left slot, 1 = right slot.
- `sdata` in 1: codec serial data, MSB first, asynchronous.
- `lft_aud` out 16: last complete left sample, signed.
- `rht_aud` out 16: last complete right sample, signed.
- `aud_vld` out 1: one-`clk` pulse when `lft_aud` and `rht_aud` both hold a new pair.
- `frm_err` out 1: one-`clk` pulse when a slot ends with fewer than 16 bits captured.

## Operation
- **Synchronizers:** `sclk`, `lrclk` and `sdata` each pass through an identical 3-flop chain (s1→s2→s3).
  - Rise strobe: `rise = sclk_s2 & ~sclk_s3`.
  - On a rise, `ws = lrclk_s2` and `bit = sdata_s2` are the sampled values.
  - All state, counter and data registers change only on `clk` edges where `rise` = 1.
- **Previous word select:** `ws_prev` holds `ws` from the previous rise. A transition rise is one where `ws != ws_prev`.
- **Counter and shift register:** `bit_cnt` is 5 bits and saturates at 16. The shift register `shreg` is 16 bits, shifting left with `bit` entering at the LSB.
- **State SYNC** (reset state):
  - No shifting.
  - On a 1→0 transition rise: `bit_cnt` ← 0, go to LFT. The bit sampled on that rise is discarded.
- **State LFT:**
  - Non-transition rise: if `bit_cnt` < 16, shift `bit` in and increment `bit_cnt`.
  - 0→1 transition rise: first, if `bit_cnt` < 16, shift this bit in as the ending word's LSB. Then evaluate the post-shift count.
    - Count = 16: `lft_hold` ← `shreg`, `bit_cnt` ← 0, go to RHT.
    - Count < 16: pulse `frm_err`, go to SYNC.
- **State RHT:**
  - Non-transition rise: same shifting rule as LFT.
  - 1→0 transition rise: same LSB rule as LFT, then evaluate the post-shift count.
    - Count = 16: `lft_aud` ← `lft_hold`, `rht_aud` ← `shreg`, pulse `aud_vld`, `bit_cnt` ← 0, go to LFT.
    - Count < 16: pulse `frm_err`, leave outputs unchanged, `bit_cnt` ← 0, go to LFT. The current 1→0 rise is a valid left start.
- **Slot length:** bits beyond the 16th in a slot (24- or 32-bit slots) are ignored. The captured value is always the 16 MSBs.
- `lft_aud` and `rht_aud` change only together, only at an `aud_vld` pulse. They always form a left/right pair from the same frame.
- `aud_vld` and `frm_err` are never high in the same cycle.

## Timing
- **Reset values:** `lft_aud` = 0, `rht_aud` = 0, `aud_vld` = 0, `frm_err` = 0. Internally: state = SYNC, `bit_cnt` = 0, `shreg` = 0, `lft_hold` = 0, `ws_prev` = 1, all synchronizer flops = 0.
- **Latency:** a raw `sclk` rising edge reaches s1 at clk edge 1 and s2 at edge 2. At clk edge 3 the registers update and `aud_vld`/`frm_err` go high. They drop at edge 4.
- **Constraint:** `sclk` high and low phases must each be at least 2 `clk` periods (`sclk` ≤ 12.5MHz). `sdata` and `lrclk` must be stable for at least 2 `clk` periods around each `sclk` rise.
- **Pulse spacing:** consecutive `aud_vld` pulses are at least 32 `sclk` periods apart, which is far above the 4-cycle processing time of the downstream averaging stage.
- **Reset mid-frame:** all registers clear immediately and the state machine restarts in SYNC. The first `aud_vld` after reset requires one 1→0 transition, a full left slot and a full right slot.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame → all outputs 0 in the same cycle. After release, no `aud_vld` until a complete frame follows a `lrclk` falling edge.
- **32-bit slots:** `sclk`=3.125MHz (16 clk period), left word 0x7FFF, right word 0x8001 → exactly one `aud_vld`. With it, `lft_aud`=0x7FFF and `rht_aud`=0x8001. The 16 trailing bits of each slot are ignored.
- **Minimum 16-bit slots:** left 0x1234, right 0xABCD, each LSB arriving on the following slot's first rise → `lft_aud`=0x1234 and `rht_aud`=0xABCD on the frame's `aud_vld`.
- **Short left slot:** `lrclk` rises after only 10 left bits → `frm_err` pulses once, no `aud_vld`, outputs hold their previous values. The next complete frame produces a correct pair.
- **Short right slot:** 12-bit right slot → `frm_err` pulses and there is no `aud_vld` for that frame. The immediately following frame yields `aud_vld` with no lost frame.
- **Back-to-back frames:** 100 frames of random data → 100 `aud_vld` pulses, each exactly 1 clk wide, every pair matching the model.
